// File: rtl/log_fifo_arbiter_pkg.sv
// Shared types and helpers for the log FIFO arbiter and its per-source buffers.
package log_fifo_arbiter_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_e;

    // A popped newline ends the owner's line and releases the lock.
    localparam logic [7:0] NEWLINE_CHAR = 8'h0A;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/log_arb_req_buf.sv
// One source's skid buffer: circular store with wrap-bit pointers plus a
// saturating counter of characters dropped on overflow.
module log_arb_req_buf
    import log_fifo_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CHAR_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [CHAR_W-1:0] push_char,
    input  logic              pop,
    input  logic              drop_clr,
    output logic [CHAR_W-1:0] head,
    output logic              empty,
    output logic              push_ok,
    output logic [CNT_W-1:0]  drop_count
);
    localparam int unsigned PTR_W   = idx_w(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    logic [CHAR_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  drop_cnt_q;
    logic              full, pop_ok, drop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;
    assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign drop_count = drop_cnt_q;

    // Pointer update; reset empties the buffer without touching storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Character storage, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_char;
    end

    // Saturating drop counter; a clear coinciding with a drop loads one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop_clr) begin
            drop_cnt_q <= drop ? CNT_ONE : '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + CNT_ONE;
        end
    end

endmodule

// File: rtl/log_fifo_arbiter.sv
// Shares the log FIFO write port between NUM_REQ character sources. The grant
// is held for a whole line so lines from different sources never interleave.
module log_fifo_arbiter
    import log_fifo_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned BUF_DEPTH    = 4,
    parameter int unsigned CHAR_W       = 8,
    parameter int unsigned DROP_CNT_W   = 16,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [NUM_REQ-1:0]             req_wr_en,
    input  logic [NUM_REQ*CHAR_W-1:0]      req_char,
    input  logic                           fifo_full,
    output logic                           fifo_wr_en,
    output logic [CHAR_W-1:0]              fifo_din,
    output logic                           grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]     grant_idx,
    output logic [NUM_REQ-1:0]             buf_empty,
    input  logic                           drop_clr,
    output logic [NUM_REQ*DROP_CNT_W-1:0]  drop_count
);
    localparam int unsigned IDX_W  = idx_w(NUM_REQ);
    localparam int unsigned IDLE_W = idx_w(LOCK_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE = 1;

    arb_state_e        state_q;
    logic [IDX_W-1:0]  owner_q, next_owner, hi_idx, lo_idx;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              hi_found, lo_found, owner_active;
    logic [CHAR_W-1:0] head [NUM_REQ];
    logic [CHAR_W-1:0] owner_head;
    logic [NUM_REQ-1:0] push_ok, pop;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_buf
        assign pop[g] = fifo_wr_en && (owner_q == IDX_W'(g));

        log_arb_req_buf #(
            .DEPTH  (BUF_DEPTH),
            .CHAR_W (CHAR_W),
            .CNT_W  (DROP_CNT_W)
        ) u_buf (
            .clk        (clk),
            .rst        (rst),
            .push       (req_wr_en[g]),
            .push_char  (req_char[g*CHAR_W +: CHAR_W]),
            .pop        (pop[g]),
            .drop_clr   (drop_clr),
            .head       (head[g]),
            .empty      (buf_empty[g]),
            .push_ok    (push_ok[g]),
            .drop_count (drop_count[g*DROP_CNT_W +: DROP_CNT_W])
        );
    end

    assign owner_head   = head[owner_q];
    assign grant_valid  = (state_q == LOCKED);
    assign grant_idx    = owner_q;
    assign fifo_wr_en   = grant_valid & enable & ~fifo_full & ~buf_empty[owner_q];
    assign fifo_din     = grant_valid ? owner_head : '0;
    assign owner_active = push_ok[owner_q] | fifo_wr_en;

    // Round-robin pick: first non-empty source above the last owner, else wrap.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!buf_empty[i]) begin
                if (i > int'(owner_q)) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = IDX_W'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(i);
                end
            end
        end
        next_owner = hi_found ? hi_idx : lo_idx;
    end

    // Grant FSM: lock on a source, release on newline, timeout or disable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= IDX_W'(NUM_REQ - 1);
            idle_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enable && !(&buf_empty)) begin
                        state_q    <= LOCKED;
                        owner_q    <= next_owner;
                        idle_cnt_q <= '0;
                    end
                end
                LOCKED: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (fifo_wr_en && (owner_head == CHAR_W'(NEWLINE_CHAR))) begin
                        state_q <= IDLE;
                    end else if (owner_active) begin
                        idle_cnt_q <= '0;
                    end else if (buf_empty[owner_q]) begin
                        // Release on the cycle the count reaches LOCK_TIMEOUT.
                        if (idle_cnt_q == IDLE_W'(LOCK_TIMEOUT - 1)) state_q <= IDLE;
                        idle_cnt_q <= idle_cnt_q + IDLE_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_log_fifo_arbiter.sv
module tb_log_fifo_arbiter;
    localparam int NUM_REQ      = 2;
    localparam int BUF_DEPTH    = 4;
    localparam int CHAR_W       = 8;
    localparam int DROP_CNT_W   = 4;
    localparam int LOCK_TIMEOUT = 64;
    localparam int IDX_W        = 1;
    localparam int DROP_MAX     = 15;
    localparam logic [7:0] NL   = 8'h0A;

    logic clk = 1'b0;
    logic rst, enable, fifo_full, drop_clr;
    logic [NUM_REQ-1:0]            req_wr_en;
    logic [NUM_REQ*CHAR_W-1:0]     req_char;
    logic                          fifo_wr_en, grant_valid;
    logic [CHAR_W-1:0]             fifo_din;
    logic [IDX_W-1:0]              grant_idx;
    logic [NUM_REQ-1:0]            buf_empty;
    logic [NUM_REQ*DROP_CNT_W-1:0] drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: one queue per source, drop tallies, lock owner.
    logic [7:0] mq [NUM_REQ][$];
    int mdrop [NUM_REQ];
    bit mlocked;
    int mowner;
    int midle;

    always #5 clk = ~clk;

    log_fifo_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .BUF_DEPTH    (BUF_DEPTH),
        .CHAR_W       (CHAR_W),
        .DROP_CNT_W   (DROP_CNT_W),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req_wr_en   (req_wr_en),
        .req_char    (req_char),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .buf_empty   (buf_empty),
        .drop_clr    (drop_clr),
        .drop_count  (drop_count)
    );

    task automatic quiet_inputs();
        enable    = 1'b1;
        fifo_full = 1'b0;
        drop_clr  = 1'b0;
        req_wr_en = '0;
        req_char  = '0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    function automatic void model_step();
        int size0 [NUM_REQ];
        bit wr, drop, act, found;
        logic [7:0] popped;
        int idx;
        for (int i = 0; i < NUM_REQ; i++) size0[i] = mq[i].size();
        wr = mlocked && enable && !fifo_full && (size0[mowner] > 0);
        popped = 8'h00;
        act = 1'b0;
        if (wr) begin
            popped = mq[mowner].pop_front();
            act = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            drop = 1'b0;
            if (req_wr_en[i]) begin
                if (mq[i].size() < BUF_DEPTH) begin
                    mq[i].push_back(req_char[i*CHAR_W +: CHAR_W]);
                    if (i == mowner) act = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
            if (drop_clr) mdrop[i] = drop ? 1 : 0;
            else if (drop && mdrop[i] < DROP_MAX) mdrop[i]++;
        end
        if (!mlocked) begin
            found = 1'b0;
            if (enable) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = (mowner + k) % NUM_REQ;
                    if (!found && size0[idx] > 0) begin
                        found = 1'b1;
                        mlocked = 1'b1;
                        mowner = idx;
                        midle = 0;
                    end
                end
            end
        end else if (!enable) begin
            mlocked = 1'b0;
        end else if (wr && popped == NL) begin
            mlocked = 1'b0;
        end else if (act) begin
            midle = 0;
        end else if (size0[mowner] == 0) begin
            midle++;
            if (midle == LOCK_TIMEOUT) mlocked = 1'b0;
        end
    endfunction

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (buf_empty !== 2'b11) begin errors++;
            $display("FAIL reset_buf_empty: got %b expected 11", buf_empty); end
        checks++; if (grant_valid !== 1'b0) begin errors++;
            $display("FAIL reset_grant_valid: got %b expected 0", grant_valid); end
        checks++; if (grant_idx !== 1'b1) begin errors++;
            $display("FAIL reset_grant_idx: got %0d expected 1", grant_idx); end
        checks++; if (fifo_wr_en !== 1'b0 || fifo_din !== 8'h00) begin errors++;
            $display("FAIL reset_fifo: got wr=%b din=%h expected wr=0 din=00", fifo_wr_en, fifo_din); end
        checks++; if (drop_count !== '0) begin errors++;
            $display("FAIL reset_drop_count: got %h expected 00", drop_count); end
        next_cycle();
    endtask

    task automatic test_single_line();
        logic [7:0] line [3];
        logic [7:0] got [$];
        int cyc [$];
        line = '{8'h41, 8'h42, NL};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req_wr_en = '0;
            if (c < 3) begin
                req_wr_en[0] = 1'b1;
                req_char[7:0] = line[c];
            end
            @(negedge clk);
            if (fifo_wr_en) begin
                got.push_back(fifo_din);
                cyc.push_back(c);
            end
            next_cycle();
        end
        req_wr_en = '0;
        checks++; if (got.size() != 3) begin errors++;
            $display("FAIL single_count: got %0d writes expected 3", got.size()); end
        while (got.size() < 3) begin got.push_back(8'hxx); cyc.push_back(-1); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (got[i] !== line[i] || cyc[i] != i + 2) begin errors++;
                $display("FAIL single_char%0d: got %h@cycle %0d expected %h@cycle %0d",
                         i, got[i], cyc[i], line[i], i + 2); end
        end
        checks++; if (grant_valid !== 1'b0 || grant_idx !== 1'b0) begin errors++;
            $display("FAIL single_release: got valid=%b idx=%0d expected valid=0 idx=0",
                     grant_valid, grant_idx); end
    endtask

    task automatic test_no_interleave();
        logic [7:0] l0 [3];
        logic [7:0] l1 [2];
        logic [7:0] exp [5];
        logic [7:0] got [$];
        l0  = '{8'h58, 8'h59, NL};
        l1  = '{8'h5A, NL};
        exp = '{8'h58, 8'h59, NL, 8'h5A, NL};
        do_reset();
        for (int c = 0; c < 14; c++) begin
            req_wr_en = '0;
            if (c < 3) begin req_wr_en[0] = 1'b1; req_char[7:0]  = l0[c]; end
            if (c < 2) begin req_wr_en[1] = 1'b1; req_char[15:8] = l1[c]; end
            @(negedge clk);
            if (fifo_wr_en) got.push_back(fifo_din);
            next_cycle();
        end
        req_wr_en = '0;
        checks++; if (got.size() != 5) begin errors++;
            $display("FAIL interleave_count: got %0d writes expected 5", got.size()); end
        while (got.size() < 5) got.push_back(8'hxx);
        for (int i = 0; i < 5; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++;
                $display("FAIL interleave_char%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        checks++; if (grant_idx !== 1'b1 || grant_valid !== 1'b0) begin errors++;
            $display("FAIL interleave_last_owner: got idx=%0d valid=%b expected idx=1 valid=0",
                     grant_idx, grant_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [5];
        logic [7:0] got [$];
        bit wrote_full;
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, NL};
        wrote_full = 1'b0;
        do_reset();
        for (int c = 0; c < 26; c++) begin
            req_wr_en = '0;
            fifo_full = (c < 10);
            if (c < 6) begin req_wr_en[0] = 1'b1; req_char[7:0] = 8'(8'h31 + c); end
            if (c == 16) begin req_wr_en[0] = 1'b1; req_char[7:0] = NL; end
            @(negedge clk);
            if (c < 10 && fifo_wr_en) wrote_full = 1'b1;
            if (c == 9) begin
                checks++; if (grant_valid !== 1'b1 || grant_idx !== 1'b0) begin errors++;
                    $display("FAIL bp_hold_lock: got valid=%b idx=%0d expected valid=1 idx=0",
                             grant_valid, grant_idx); end
                checks++; if (drop_count[3:0] !== 4'd2) begin errors++;
                    $display("FAIL bp_drop_count: got %0d expected 2", drop_count[3:0]); end
            end
            if (c >= 10 && fifo_wr_en) got.push_back(fifo_din);
            next_cycle();
        end
        req_wr_en = '0;
        checks++; if (wrote_full) begin errors++;
            $display("FAIL bp_write_while_full: got write=1 expected write=0"); end
        checks++; if (got.size() != 5) begin errors++;
            $display("FAIL bp_count: got %0d writes expected 5", got.size()); end
        while (got.size() < 5) got.push_back(8'hxx);
        for (int i = 0; i < 5; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++;
                $display("FAIL bp_char%0d: got %h expected %h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c < 76; c++) begin
            req_wr_en = '0;
            if (c == 0)  begin req_wr_en[1] = 1'b1; req_char[15:8] = 8'h51; end
            if (c == 70) begin req_wr_en[0] = 1'b1; req_char[7:0]  = 8'h52; end
            @(negedge clk);
            if (c == 2) begin
                checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h51) begin errors++;
                    $display("FAIL to_write_q: got wr=%b din=%h expected wr=1 din=51",
                             fifo_wr_en, fifo_din); end
            end
            if (c == 66) begin
                checks++; if (grant_valid !== 1'b1) begin errors++;
                    $display("FAIL to_early_release: got valid=%b expected 1", grant_valid); end
            end
            if (c == 67) begin
                checks++; if (grant_valid !== 1'b0 || grant_idx !== 1'b1) begin errors++;
                    $display("FAIL to_release: got valid=%b idx=%0d expected valid=0 idx=1",
                             grant_valid, grant_idx); end
            end
            if (c == 72) begin
                checks++; if (grant_valid !== 1'b1 || grant_idx !== 1'b0 ||
                              fifo_wr_en !== 1'b1 || fifo_din !== 8'h52) begin errors++;
                    $display("FAIL to_regrant: got valid=%b idx=%0d wr=%b din=%h expected 1 0 1 52",
                             grant_valid, grant_idx, fifo_wr_en, fifo_din); end
            end
            next_cycle();
        end
        req_wr_en = '0;
    endtask

    task automatic test_drop_sat();
        bit any_write;
        any_write = 1'b0;
        do_reset();
        enable = 1'b0;
        for (int c = 0; c < 28; c++) begin
            req_wr_en = '0;
            drop_clr  = 1'b0;
            if (c < 24 || c == 24) begin req_wr_en[0] = 1'b1; req_char[7:0] = 8'(c); end
            if (c == 24 || c == 26) drop_clr = 1'b1;
            @(negedge clk);
            if (fifo_wr_en || grant_valid) any_write = 1'b1;
            if (c == 24) begin
                checks++; if (drop_count[3:0] !== 4'd15 || buf_empty[0] !== 1'b0) begin errors++;
                    $display("FAIL sat_value: got cnt=%0d empty=%b expected cnt=15 empty=0",
                             drop_count[3:0], buf_empty[0]); end
            end
            if (c == 25) begin
                checks++; if (drop_count !== 8'h01) begin errors++;
                    $display("FAIL clr_with_drop: got %h expected 01", drop_count); end
            end
            if (c == 27) begin
                checks++; if (drop_count !== 8'h00) begin errors++;
                    $display("FAIL clr_plain: got %h expected 00", drop_count); end
            end
            next_cycle();
        end
        quiet_inputs();
        checks++; if (any_write) begin errors++;
            $display("FAIL sat_disabled_write: got write/grant=1 expected 0"); end
    endtask

    task automatic test_reset_midline();
        bit bad;
        bad = 1'b0;
        do_reset();
        fifo_full = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req_wr_en = '0;
            if (c < 3) begin req_wr_en[0] = 1'b1; req_char[7:0]  = 8'(8'h61 + c); end
            if (c < 5) begin req_wr_en[1] = 1'b1; req_char[15:8] = 8'(8'h71 + c); end
            @(negedge clk);
            if (c == 6) begin
                checks++; if (grant_valid !== 1'b1 || grant_idx !== 1'b0 ||
                              drop_count[7:4] !== 4'd1) begin errors++;
                    $display("FAIL rm_setup: got valid=%b idx=%0d drop1=%0d expected 1 0 1",
                             grant_valid, grant_idx, drop_count[7:4]); end
            end
            next_cycle();
        end
        req_wr_en = '0;
        fifo_full = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (fifo_wr_en !== 1'b0 || fifo_din !== 8'h00) begin errors++;
            $display("FAIL rm_no_write: got wr=%b din=%h expected wr=0 din=00", fifo_wr_en, fifo_din); end
        checks++; if (buf_empty !== 2'b11 || grant_valid !== 1'b0 || grant_idx !== 1'b1 ||
                      drop_count !== 8'h00) begin errors++;
            $display("FAIL rm_state: got empty=%b valid=%b idx=%0d drops=%h expected 11 0 1 00",
                     buf_empty, grant_valid, grant_idx, drop_count); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (fifo_wr_en || grant_valid) bad = 1'b1;
            next_cycle();
        end
        checks++; if (bad) begin errors++;
            $display("FAIL rm_stale_write: got write/grant=1 after reset expected 0"); end
    endtask

    task automatic test_random();
        bit exp_wr;
        logic [NUM_REQ-1:0] exp_empty;
        logic [NUM_REQ*DROP_CNT_W-1:0] exp_drop;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin mq[i].delete(); mdrop[i] = 0; end
        mlocked = 1'b0;
        mowner  = NUM_REQ - 1;
        midle   = 0;
        for (int c = 0; c < 1000; c++) begin
            enable    = ($urandom_range(0, 9) != 0);
            fifo_full = ($urandom_range(0, 4) == 0);
            drop_clr  = ($urandom_range(0, 30) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                req_wr_en[i] = ((c % 250) < 170) && ($urandom_range(0, 2) == 0);
                req_char[i*CHAR_W +: CHAR_W] = ($urandom_range(0, 5) == 0) ? NL
                                               : 8'($urandom_range(32, 126));
            end
            @(negedge clk);
            exp_wr = mlocked && enable && !fifo_full && (mq[mowner].size() > 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                exp_empty[i] = (mq[i].size() == 0);
                exp_drop[i*DROP_CNT_W +: DROP_CNT_W] = DROP_CNT_W'(mdrop[i]);
            end
            checks++; if (fifo_wr_en !== exp_wr) begin errors++;
                $display("FAIL rnd_wr_en c%0d: got %b expected %b", c, fifo_wr_en, exp_wr); end
            if (exp_wr) begin
                checks++; if (fifo_din !== mq[mowner][0]) begin errors++;
                    $display("FAIL rnd_din c%0d: got %h expected %h", c, fifo_din, mq[mowner][0]); end
            end
            if (!mlocked) begin
                checks++; if (fifo_din !== 8'h00) begin errors++;
                    $display("FAIL rnd_din_idle c%0d: got %h expected 00", c, fifo_din); end
            end
            checks++; if (grant_valid !== mlocked || grant_idx !== IDX_W'(mowner)) begin errors++;
                $display("FAIL rnd_grant c%0d: got valid=%b idx=%0d expected valid=%b idx=%0d",
                         c, grant_valid, grant_idx, mlocked, mowner); end
            checks++; if (buf_empty !== exp_empty) begin errors++;
                $display("FAIL rnd_empty c%0d: got %b expected %b", c, buf_empty, exp_empty); end
            checks++; if (drop_count !== exp_drop) begin errors++;
                $display("FAIL rnd_drops c%0d: got %h expected %h", c, drop_count, exp_drop); end
            model_step();
            next_cycle();
        end
        quiet_inputs();
    endtask

    initial begin
        rst = 1'b1;
        quiet_inputs();
        test_reset();
        test_single_line();
        test_no_interleave();
        test_backpressure();
        test_timeout();
        test_drop_sat();
        test_reset_midline();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/log_fifo_arbiter.md
Name: log_fifo_arbiter

Overview:
- Shares the single FPGA log FIFO write port between NUM_REQ character sources, e.g. the Caliptra generic-output-wire char stream and the MCU char stream.
- Each source gets a small skid buffer. A round-robin arbiter grants one source at a time and holds the grant for a whole text line, so lines from different sources never interleave.
- Counts characters dropped on buffer overflow per source. The counters are exposed to the realtime register block.

Parameters:
- NUM_REQ, 2, number of character sources (2..4).
- BUF_DEPTH, 4, entries per source skid buffer (power of 2, ≥2).
- CHAR_W, 8, character width.
- DROP_CNT_W, 16, width of each saturating drop counter.
- LOCK_TIMEOUT, 64, consecutive idle cycles with an empty owner buffer before the lock is released.

Ports:
- clk  in  1  core clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  arbitration enable; when low, nothing is written to the log FIFO.
- req_wr_en  in  NUM_REQ  per-source character strobe, one char per cycle per source.
- req_char  in  NUM_REQ*CHAR_W  per-source character; source i occupies bits [i*CHAR_W +: CHAR_W].
- fifo_full  in  1  log FIFO full flag.
- fifo_wr_en  out  1  log FIFO write strobe.
- fifo_din  out  CHAR_W  log FIFO write data.
- grant_valid  out  1  an owner is locked.
- grant_idx  out  $clog2(NUM_REQ)  current or last owner.
- buf_empty  out  NUM_REQ  per-source buffer empty.
- drop_clr  in  1  clears all drop counters.
- drop_count  out  NUM_REQ*DROP_CNT_W  per-source drop counters.

Behaviour:
- Reset values:
  - all buffers empty, so buf_empty is all-ones;
  - FSM in IDLE;
  - grant_valid=0, grant_idx=NUM_REQ-1, so source 0 wins first;
  - fifo_wr_en=0, fifo_din=0;
  - drop counters 0.
- Reset mid-line discards all buffered chars. No partial write is issued after rst asserts.
- Buffer write: req_wr_en[i]=1 with buffer i not full pushes req_char[i] at the clock edge.
  - If buffer i is full and not popped that cycle, the char is dropped and drop_count[i] increments, saturating at all-ones.
  - A simultaneous push and pop on a full buffer is accepted, with no drop.
- Buffers keep accepting chars while enable=0.
- fifo_din is the owner buffer head when grant_valid=1, otherwise 0.
- fifo_wr_en = grant_valid & enable & ~fifo_full & ~buf_empty[owner]. This is combinational from registered state and fifo_full, so a write is never issued while full. A pop occurs on each cycle fifo_wr_en=1.
- FSM IDLE:
  - If enable=1 and any buffer is non-empty, grant the first non-empty source searching grant_idx+1, grant_idx+2, … modulo NUM_REQ.
  - Register the owner and go to LOCKED. There is no write in the IDLE cycle.
- FSM LOCKED:
  - Return to IDLE, keeping grant_idx, on any of:
    - (a) the popped char equals 8'h0A (newline); the newline itself is written first;
    - (b) the idle counter reaches LOCK_TIMEOUT;
    - (c) enable=0, which releases at the next edge with no write in that cycle.
  - The idle counter increments each LOCKED cycle with buf_empty[owner]=1. It clears on any push or pop of the owner buffer and on entry to LOCKED.
  - fifo_full stalls do not count as idle.
- Latency: a char pushed at edge N to an empty, un-owned buffer, with enable=1 and fifo_full=0, has fifo_wr_en=1 in cycle N+2.
- Throughput: one char per cycle while locked and not stalled.
- drop_clr: all counters go to 0 at the edge. A simultaneous drop on source i loads 1 into drop_count[i].

Decomposition:
- Package log_fifo_arbiter_pkg holds:
  - arb_state_e {IDLE, LOCKED};
  - NEWLINE_CHAR = 8'h0A;
  - localparam functions for index width.
- Sub-module log_arb_req_buf holds one source's circular buffer (rd/wr pointers with extra wrap bit, full/empty) plus its saturating drop counter. It is instantiated NUM_REQ times via generate.

Test Plan:
- Single-source line: src0 writes "AB\n" on consecutive cycles, fifo_full=0 → fifo_wr_en in cycles 2,3,4, fifo_din 0x41,0x42,0x0A; then IDLE, grant_idx=0.
- No interleave: src0 writes "XY\n" while src1 writes "Z\n" in the same cycles → FIFO receives 58,59,0A,5A,0A in that order; grant_idx becomes 1 after the src1 line.
- Backpressure: fifo_full=1 for 10 cycles mid-line with src0 writing 6 chars, BUF_DEPTH=4 → 4 buffered, drop_count[0]=2, no write while full, no timeout release; after full drops, the remaining chars are written.
- Timeout: src1 writes "Q" with no newline → after Q is written and 64 idle cycles, grant_valid=0; src0 char then arrives → granted to src0.
- Drop saturation/clear: DROP_CNT_W=4, src0 buffer held full with 20 overflow writes → drop_count[0]=15; drop_clr coinciding with an overflow → drop_count[0]=1.
- Reset mid-line: assert rst while LOCKED with 3 chars buffered → fifo_wr_en=0 immediately, all buffers empty, grant_idx=NUM_REQ-1, counters 0.
